// File: rtl/servo_pwm_array.sv
// Multi-channel hobby-servo PWM generator: per-channel shadow targets written over
// a one-cycle strobe, frame-synchronous active widths with optional slew limiting.
module servo_pwm_array #(
  parameter int NUM_CH       = 4,
  parameter int CLK_DIV      = 391,
  parameter int PERIOD_TICKS = 4096,
  parameter int CENTER       = 384,
  parameter int RAMP_STEP    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [2:0]        wr_ch,
  input  logic [9:0]        wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              frame_start,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] busy
);

  localparam int              CW       = $clog2(PERIOD_TICKS);
  localparam int              DW       = $clog2(CLK_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   FRM_LAST = CW'(PERIOD_TICKS - 1);
  localparam logic [9:0]      CTR      = 10'(CENTER);
  localparam logic [9:0]      STEP     = 10'(RAMP_STEP);
  localparam logic [3:0]      NCH      = 4'(NUM_CH);

  logic [DW-1:0]     div_cnt;
  logic [CW-1:0]     frame_cnt;
  logic              tick;
  logic [9:0]        act    [NUM_CH];
  logic [9:0]        target [NUM_CH];
  logic [NUM_CH-1:0] enable;

  // Write handshake: wr_en is a single-cycle strobe with no back-pressure; every
  // strobe is answered by exactly one wr_ack pulse on the next clk, wr_err qualifying it.
  logic       wr_valid;
  logic [9:0] wr_offset;
  logic [9:0] wr_target;
  logic [11:0] frame_w;

  assign tick     = (div_cnt == DIV_LAST);
  assign wr_valid = wr_en && ({1'b0, wr_ch} < NCH);
  assign frame_w  = 12'(frame_cnt);

  // Mode only scales the offset, so it is folded into the stored target width.
  always_comb begin
    wr_offset = wr_data[8] ? {2'b00, wr_data[6:0], 1'b0} : {3'b000, wr_data[6:0]};
    wr_target = wr_data[7] ? (CTR + wr_offset) : (CTR - wr_offset);
  end

  function automatic logic [9:0] ramp_to(input logic [9:0] a, input logic [9:0] t);
    logic [9:0] diff;
    logic [9:0] step;
    if (STEP == 10'd0) return t;
    diff = (a < t) ? (t - a) : (a - t);
    step = (diff > STEP) ? STEP : diff;
    return (a < t) ? (a + step) : (a - step);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt     <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
      wr_ack      <= 1'b0;
      wr_err      <= 1'b0;
      pwm_out     <= '0;
      enable      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        act[i]    <= CTR;
        target[i] <= CTR;
      end
    end else begin
      div_cnt     <= tick ? '0 : div_cnt + DW'(1);
      if (tick) frame_cnt <= frame_cnt + CW'(1);
      frame_start <= tick && (frame_cnt == FRM_LAST);
      wr_ack      <= wr_en;
      wr_err      <= wr_en && !wr_valid;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_valid && (wr_ch == 3'(i))) begin
          target[i] <= wr_target;
          enable[i] <= wr_data[9];
        end
        // Widths move only on the frame boundary so a pulse is never cut short.
        if (frame_start) act[i] <= ramp_to(act[i], target[i]);
        pwm_out[i] <= enable[i] && (frame_w < {2'b00, act[i]});
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_CH; i++) busy[i] = (act[i] != target[i]);
  end

endmodule

// File: tb/tb_servo_pwm_array.sv
// Directed bench for servo_pwm_array: an immediate-jump instance and a slew-limited
// instance share one write bus; pulse widths are measured per frame in clks.
module tb_servo_pwm_array;

  localparam int FRAME_CLKS = 3072;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_ch;
  logic [9:0] wr_data;
  logic       wr_ack, wr_err, frame_start;
  logic [3:0] pwm_out, busy;
  logic       wr_ack_r, wr_err_r, frame_start_r;
  logic [3:0] pwm_out_r, busy_r;

  int checks   = 0;
  int failures = 0;
  int hi   [4];
  int hi_r [4];
  logic [3:0] busy_s, busy_rs;

  always #5 clk = ~clk;

  servo_pwm_array #(.NUM_CH(4), .CLK_DIV(3), .PERIOD_TICKS(1024), .CENTER(384), .RAMP_STEP(0)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .frame_start(frame_start),
    .pwm_out(pwm_out), .busy(busy));

  servo_pwm_array #(.NUM_CH(4), .CLK_DIV(3), .PERIOD_TICKS(1024), .CENTER(384), .RAMP_STEP(16)) dut_r (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .wr_ack(wr_ack_r), .wr_err(wr_err_r), .frame_start(frame_start_r),
    .pwm_out(pwm_out_r), .busy(busy_r));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] wd(input logic en, input logic md, input logic dr,
                                    input logic [6:0] mg);
    return {en, md, dr, mg};
  endfunction

  // Drive one strobe at a negedge; the ack is checked at the following negedge.
  task automatic do_write(input string tag, input logic [2:0] ch, input logic [9:0] data,
                          input logic exp_err);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    check({tag, "_ack"}, wr_ack, 1'b1);
    check({tag, "_err"}, wr_err, exp_err);
  endtask

  task automatic wait_fs(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 4000);
    check(tag, frame_start, 1'b1);
  endtask

  // Call at the negedge of a frame_start clk; returns at the next frame_start clk.
  task automatic measure_frame();
    for (int c = 0; c < 4; c++) begin
      hi[c]   = 0;
      hi_r[c] = 0;
    end
    for (int n = 0; n < FRAME_CLKS; n++) begin
      @(negedge clk);
      if (n == 0) begin
        busy_s  = busy;
        busy_rs = busy_r;
      end
      for (int c = 0; c < 4; c++) begin
        hi[c]   += int'(pwm_out[c]);
        hi_r[c] += int'(pwm_out_r[c]);
      end
    end
  endtask

  initial begin
    int n;
    int exp_w;
    reset   = 1'b0;
    wr_en   = 1'b1;
    wr_ch   = 3'd0;
    wr_data = wd(1'b1, 1'b0, 1'b1, 7'd127);
    repeat (4) @(negedge clk);
    check("rst_pwm", pwm_out, 4'b0000);
    check("rst_busy", busy, 4'b0000);
    check("rst_ack", wr_ack, 1'b0);
    check("rst_err", wr_err, 1'b0);
    check("rst_fs", frame_start, 1'b0);
    wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 4000);
    check("first_fs_clks", n, 3072);
    check("rst_write_ignored_busy", busy, 4'b0000);

    @(negedge clk);
    do_write("w_ch0", 3'd0, wd(1'b1, 1'b0, 1'b1, 7'd127), 1'b0);
    do_write("w_ch2", 3'd2, wd(1'b1, 1'b1, 1'b0, 7'd127), 1'b0);
    do_write("w_ch5", 3'd5, wd(1'b1, 1'b0, 1'b1, 7'd50), 1'b1);
    check("ch5_ack_r", wr_ack_r, 1'b1);
    @(negedge clk);
    check("ack_one_clk", wr_ack, 1'b0);
    check("busy_after_writes", busy, 4'b0101);

    wait_fs("fs_f2");
    measure_frame();
    check("f2_busy", busy_s, 4'b0000);
    check("f2_ch0_width", hi[0], 511 * 3);
    check("f2_ch1_low", hi[1], 0);
    check("f2_ch2_width", hi[2], 130 * 3);
    check("f2_ch3_low", hi[3], 0);
    check("f2_aligned_fs", frame_start, 1'b1);

    // Write in the frame_start clk itself: act must keep 511 for this frame.
    do_write("w_coinc", 3'd0, wd(1'b1, 1'b0, 1'b1, 7'd10), 1'b0);
    check("coinc_busy", busy[0], 1'b1);
    wait_fs("fs_f4");
    measure_frame();
    check("f4_ch0_width", hi[0], 394 * 3);

    @(negedge clk);
    do_write("w_b2b_a", 3'd0, wd(1'b1, 1'b0, 1'b1, 7'd10), 1'b0);
    do_write("w_b2b_b", 3'd0, wd(1'b1, 1'b0, 1'b1, 7'd50), 1'b0);
    check("b2b_busy", busy[0], 1'b1);
    wait_fs("fs_f6");
    measure_frame();
    check("f6_ch0_width", hi[0], 434 * 3);
    check("f6_ch2_width", hi[2], 130 * 3);

    @(negedge clk);
    do_write("w_ramp", 3'd1, wd(1'b1, 1'b0, 1'b1, 7'd127), 1'b0);
    wait_fs("fs_ramp");
    for (int k = 0; k < 8; k++) begin
      measure_frame();
      exp_w = (k < 7) ? (400 + 16 * k) : 511;
      check($sformatf("ramp_w%0d", k), hi_r[1], exp_w * 3);
      check($sformatf("ramp_busy%0d", k), busy_rs[1], (k < 7) ? 1'b1 : 1'b0);
      if (k == 0) check("jump_ch1_width", hi[1], 511 * 3);
    end

    repeat (10) @(negedge clk);
    check("pre_rst_pwm0", pwm_out[0], 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_pwm", pwm_out, 4'b0000);
    check("mid_rst_pwm_r", pwm_out_r, 4'b0000);
    check("mid_rst_busy", busy, 4'b0000);
    check("mid_rst_fs", frame_start, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    do_write("w_post", 3'd0, wd(1'b1, 1'b0, 1'b0, 7'd0), 1'b0);
    check("post_busy", busy, 4'b0000);
    check("post_busy_r", busy_r, 4'b0000);
    wait_fs("fs_post");
    measure_frame();
    check("post_ch0_width", hi[0], 384 * 3);
    check("post_ch1_off", hi[1], 0);
    check("post_ch2_off", hi[2], 0);
    check("post_r_ch1_off", hi_r[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/servo_pwm_array.md
SERVO_PWM_ARRAY -- requirements
Module: servo_pwm_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of servo channels (1..8).
REQ-002 SHALL have parameter CLK_DIV, default 391, clk cycles per PWM tick (>=2).
REQ-003 SHALL have parameter PERIOD_TICKS, default 4096, ticks per PWM frame (power of two, 2^CW, CW<=12).
REQ-004 SHALL have parameter CENTER, default 384, neutral pulse width in ticks.
REQ-005 SHALL have parameter RAMP_STEP, default 0, maximum width change per frame in ticks; 0 means an immediate jump.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-007 SHALL have port reset, input, 1, synchronous active-low reset (reset==0 resets on the next posedge).
REQ-008 SHALL have port wr_en, input, 1, one-cycle write strobe.
REQ-009 SHALL have port wr_ch, input, 3, target channel index.
REQ-010 SHALL have port wr_data, input, 10, fields {enable[9], mode[8], dir[7], mag[6:0]}.
REQ-011 SHALL have port wr_ack, output, 1, write accepted or rejected, one cycle after wr_en.
REQ-012 SHALL have port wr_err, output, 1, valid with wr_ack; 1 when wr_ch>=NUM_CH.
REQ-013 SHALL have port frame_start, output, 1, one-cycle pulse at the first clk of each frame.
REQ-014 SHALL have port pwm_out, output, NUM_CH, registered servo pulses.
REQ-015 SHALL have port busy, output, NUM_CH, 1 while a channel's active width differs from its target.

Function
REQ-016 SHALL keep a tick counter 0..CLK_DIV-1 that asserts an internal tick for one clk each time it wraps, giving exactly one tick per CLK_DIV clks.
REQ-017 SHALL advance a CW-bit frame counter by 1 per tick, wrapping PERIOD_TICKS-1 -> 0.
REQ-018 SHALL assert frame_start for the single clk in which the frame counter enters 0.
REQ-019 SHALL hold, per channel, a shadow register {enable, mode, target[9:0]} and an active width register act[9:0].
REQ-020 SHALL compute target on an accepted write as: mode 0 (continuous) offset = mag (0..127); mode 1 (positional) offset = mag*2 (0..254); target = CENTER - offset when dir=0, CENTER + offset when dir=1; 10-bit unsigned.
REQ-021 SHALL update the shadow register on the clk after wr_en when wr_ch<NUM_CH, and pulse wr_ack=1 with wr_err=0 on that same clk.
REQ-022 SHALL leave all state unchanged when wr_en is high and wr_ch>=NUM_CH, and pulse wr_ack=1 with wr_err=1.
REQ-023 SHALL accept back-to-back writes on consecutive clks; on the same channel the last write before a frame boundary wins.
REQ-024 SHALL never change act mid-frame; act is updated only in the frame_start cycle.
REQ-025 SHALL, at frame_start, set act=target when RAMP_STEP=0, else move act toward target by min(RAMP_STEP, |target-act|).
REQ-026 SHALL treat a write landing in the frame_start clk itself as taking effect at the following frame.
REQ-027 SHALL drive pwm_out[i] registered = enable_i && (frame counter < act_i), so the pulse is high for act_i ticks starting at frame_start; pwm_out[i] SHALL lag the counter by one clk.
REQ-028 SHALL force pwm_out[i]=0 while enable_i=0 and SHALL keep ramping act_i while disabled.
REQ-029 SHALL drive busy[i]=(act_i != target_i) from registered state.
REQ-030 SHALL clamp nothing beyond REQ-020; the integrator SHALL choose CENTER so that CENTER-254>=0 and CENTER+254<PERIOD_TICKS.

Reset
REQ-031 SHALL, while reset==0 at a posedge, clear the tick counter and frame counter, set every act and target to CENTER, set enable=0 and mode=0, and drive pwm_out, busy, wr_ack, wr_err and frame_start to 0.
REQ-032 SHALL ignore wr_en during reset; the first frame_start SHALL occur in the clk where the frame counter first re-enters 0 after reset is released.
REQ-033 SHALL abort any in-progress pulse or ramp when reset is asserted mid-frame, with outputs low on the next clk.

Verification (CLK_DIV=3, PERIOD_TICKS=1024, CENTER=384, NUM_CH=4)
REQ-034 Write ch0 {en=1,mode=0,dir=1,mag=127}, RAMP_STEP=0 -> from the next frame, pwm_out[0] high for 511 ticks (1533 clks) per 3072-clk frame.
REQ-035 Write ch2 {en=1,mode=1,dir=0,mag=127} -> pwm_out[2] high for 130 ticks; the other channels stay low.
REQ-036 RAMP_STEP=16, ch1 target changes from 384 to 511 -> widths 400, 416, ..., 496, 511 on successive frames; busy[1] drops in the frame where the width reaches 511.
REQ-037 Write wr_ch=5 -> wr_ack=1 and wr_err=1 for one clk; no pwm or shadow change.
REQ-038 Write ch0 twice in one frame (mag 10, then mag 50, dir=1) -> the next frame width is 434; a write coincident with frame_start applies one frame later.
REQ-039 Assert reset mid-pulse -> pwm_out=0 on the next clk; after release every channel is disabled and act=384.
